rf_writeback_arbiter: RTL and testbench

- Shares the single, always-enabled write port of dual_port_reg_file between two sources: the in-order pipeline WB stage and a long-latency unit (LU), such as mul/div or a miss-returning load.
- LU results are buffered in a small FIFO. Pipeline writebacks normally win the port.
- A starvation counter forces the pipeline to stall so that queued LU results drain.
- Exports a busy mask of registers with queued writes, used by the decode hazard logic.

---
 rtl/rf_wb_pkg.sv | 24 ++
 rtl/rf_wb_fifo.sv | 82 ++++++++
 rtl/rf_writeback_arbiter.sv | 107 ++++++++++
 tb/tb_rf_writeback_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback arbiter: source encoding,
// LU result entry layout and the register one-hot helper.
package rf_wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_LU   = 2'd2
    } wr_src_t;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } lu_entry_t;

    function automatic logic [31:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        rd_onehot = 32'd1 << rd;
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular buffer of pending LU results with per-entry WAW kill and a
// registered mask of registers that still have a live queued write.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  lu_entry_t             push_entry_i,
    input  logic                  pop_i,
    input  logic                  kill_i,
    input  logic [REG_ADDR_W-1:0] kill_rd_i,
    output logic                  full_o,
    output logic                  empty_o,
    output lu_entry_t             head_o,
    output logic [31:0]           busy_mask_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    lu_entry_t         mem_q [DEPTH];
    lu_entry_t         mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic [31:0]       busy_q, busy_d;

    assign full_o      = (count_q == (PW+1)'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign head_o      = mem_q[rd_ptr_q];
    assign busy_mask_o = busy_q;

    // Vacated slots are cleared to dead so the live bits alone define the mask.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        busy_d   = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (kill_i && (mem_q[i].rd == kill_rd_i)) mem_d[i].live = 1'b0;
        end

        if (pop_i) begin
            mem_d[rd_ptr_q].live = 1'b0;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push_i) begin
            mem_d[wr_ptr_q] = push_entry_i;
            if (kill_i && (push_entry_i.rd == kill_rd_i)) mem_d[wr_ptr_q].live = 1'b0;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        count_d = count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);

        for (int i = 0; i < DEPTH; i++) begin
            if (mem_d[i].live) busy_d = busy_d | rd_onehot(mem_d[i].rd);
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Shares the register file write port between the pipeline WB stage and a
// buffered long-latency unit, with a starvation limit that stalls WB.
module rf_writeback_arbiter #(
    parameter int XLEN         = rf_wb_pkg::XLEN,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_wb_valid,
    input  logic [4:0]          i_wb_rd,
    input  logic [XLEN-1:0]     i_wb_data,
    output logic                o_wb_stall,
    input  logic                i_lu_valid,
    input  logic [4:0]          i_lu_rd,
    input  logic [XLEN-1:0]     i_lu_data,
    output logic                o_lu_ready,
    output logic [4:0]          o_rf_dest_addr,
    output logic [XLEN-1:0]     o_rf_data,
    output logic [31:0]         o_busy_mask,
    output rf_wb_pkg::wr_src_t  o_wr_src
);

    import rf_wb_pkg::*;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;
    logic          full, empty;
    lu_entry_t     head, push_entry;
    logic [31:0]   fifo_busy;
    logic          wb_req, head_live, force_lu;
    logic          push, pop, kill;

    rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .kill_i       (kill),
        .kill_rd_i    (i_wb_rd),
        .full_o       (full),
        .empty_o      (empty),
        .head_o       (head),
        .busy_mask_o  (fifo_busy)
    );

    assign push_entry = '{live: 1'b1, rd: i_lu_rd, data: i_lu_data};
    assign o_busy_mask = rst ? '0 : fifo_busy;

    always_comb begin
        o_wr_src       = SRC_NONE;
        o_wb_stall     = 1'b0;
        o_rf_dest_addr = '0;
        o_rf_data      = '0;
        o_lu_ready     = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        kill           = 1'b0;
        wb_req         = i_wb_valid && (i_wb_rd != '0);
        head_live      = !empty && head.live;
        force_lu       = (starve_q == STARVE_MAX) && head_live;

        if (!rst) begin
            o_lu_ready = !full;
            if (force_lu) begin
                o_wr_src   = SRC_LU;
                o_wb_stall = wb_req;
            end else if (wb_req) begin
                o_wr_src = SRC_WB;
            end else if (head_live) begin
                o_wr_src = SRC_LU;
            end

            case (o_wr_src)
                SRC_WB: begin
                    o_rf_dest_addr = i_wb_rd;
                    o_rf_data      = i_wb_data;
                end
                SRC_LU: begin
                    o_rf_dest_addr = head.rd;
                    o_rf_data      = head.data;
                end
                default: ;
            endcase

            // A dead head leaves without touching the port.
            kill = (o_wr_src == SRC_WB);
            pop  = (o_wr_src == SRC_LU) || (!empty && !head.live);
            push = i_lu_valid && o_lu_ready && (i_lu_rd != '0);
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (empty || pop)                             starve_d = '0;
        else if (head_live && (starve_q < STARVE_MAX)) starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench: a cycle table for reset, LU-alone and starvation priority,
// then hand sequences for full FIFO, WAW kill, x0 filtering and mid-run reset.
module tb_rf_writeback_arbiter;

    import rf_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_wb_valid;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_data;
    logic        o_wb_stall;
    logic        i_lu_valid;
    logic [4:0]  i_lu_rd;
    logic [31:0] i_lu_data;
    logic        o_lu_ready;
    logic [4:0]  o_rf_dest_addr;
    logic [31:0] o_rf_data;
    logic [31:0] o_busy_mask;
    wr_src_t     o_wr_src;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] rf [32];
    logic        bad_write = 1'b0;

    always #5 clk = ~clk;

    rf_writeback_arbiter #(.XLEN(32), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_wb_valid     (i_wb_valid),
        .i_wb_rd        (i_wb_rd),
        .i_wb_data      (i_wb_data),
        .o_wb_stall     (o_wb_stall),
        .i_lu_valid     (i_lu_valid),
        .i_lu_rd        (i_lu_rd),
        .i_lu_data      (i_lu_data),
        .o_lu_ready     (o_lu_ready),
        .o_rf_dest_addr (o_rf_dest_addr),
        .o_rf_data      (o_rf_data),
        .o_busy_mask    (o_busy_mask),
        .o_wr_src       (o_wr_src)
    );

    // Register file model: no write enable, writes land at the posedge.
    always @(posedge clk) begin
        if (!rst && o_rf_dest_addr != 5'd0) begin
            rf[o_rf_dest_addr] <= o_rf_data;
            if ((o_rf_dest_addr == 5'd9 && o_rf_data == 32'd1) ||
                (o_rf_dest_addr == 5'd14 && o_rf_data == 32'd6))
                bad_write <= 1'b1;
        end
    end

    typedef struct {
        string       name;
        logic        rst;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        luv;
        logic [4:0]  lurd;
        logic [31:0] lud;
        logic        e_stall;
        logic        e_ready;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [1:0]  e_src;
        logic [31:0] e_busy;
    } vec_t;

    function automatic vec_t mk(string n, logic r, logic wv, logic [4:0] wr, logic [31:0] wd,
                                logic lv, logic [4:0] lr, logic [31:0] ld,
                                logic es, logic er, logic [4:0] ea, logic [31:0] ed,
                                logic [1:0] esrc, logic [31:0] eb);
        vec_t v;
        v.name = n; v.rst = r; v.wbv = wv; v.wbrd = wr; v.wbd = wd;
        v.luv = lv; v.lurd = lr; v.lud = ld;
        v.e_stall = es; v.e_ready = er; v.e_addr = ea; v.e_data = ed;
        v.e_src = esrc; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drv(input logic r, input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        rst = r; i_wb_valid = wv; i_wb_rd = wr; i_wb_data = wd;
        i_lu_valid = lv; i_lu_rd = lr; i_lu_data = ld;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [79:0] outs();
        return 80'({o_wb_stall, o_lu_ready, o_rf_dest_addr, o_rf_data, 2'(o_wr_src), o_busy_mask});
    endfunction

    vec_t vt [14];

    initial begin
        // stall, ready, addr, data, src, busy
        vt[0]  = mk("rst_active", 1, 1, 3, 32'h33, 1, 5, 32'h55,  0, 0, 0, 0, SRC_NONE, 0);
        vt[1]  = mk("rst_idle",   1, 0, 0, 0,      0, 0, 0,       0, 0, 0, 0, SRC_NONE, 0);
        vt[2]  = mk("idle",       0, 0, 0, 0,      0, 0, 0,       0, 1, 0, 0, SRC_NONE, 0);
        vt[3]  = mk("lu_offer",   0, 0, 0, 0,      1, 5, 32'hDEADBEEF, 0, 1, 0, 0, SRC_NONE, 0);
        vt[4]  = mk("lu_write",   0, 0, 0, 0,      0, 0, 0,       0, 1, 5, 32'hDEADBEEF, SRC_LU, 32'h20);
        vt[5]  = mk("lu_done",    0, 0, 0, 0,      0, 0, 0,       0, 1, 0, 0, SRC_NONE, 0);
        vt[6]  = mk("pri_enq",    0, 1, 3, 32'h33, 1, 7, 32'h77,  0, 1, 3, 32'h33, SRC_WB, 0);
        vt[7]  = mk("pri_wb1",    0, 1, 3, 32'h33, 0, 0, 0,       0, 1, 3, 32'h33, SRC_WB, 32'h80);
        vt[8]  = mk("pri_wb2",    0, 1, 3, 32'h33, 0, 0, 0,       0, 1, 3, 32'h33, SRC_WB, 32'h80);
        vt[9]  = mk("pri_wb3",    0, 1, 3, 32'h33, 0, 0, 0,       0, 1, 3, 32'h33, SRC_WB, 32'h80);
        vt[10] = mk("pri_wb4",    0, 1, 3, 32'h33, 0, 0, 0,       0, 1, 3, 32'h33, SRC_WB, 32'h80);
        vt[11] = mk("pri_force",  0, 1, 3, 32'h33, 0, 0, 0,       1, 1, 7, 32'h77, SRC_LU, 32'h80);
        vt[12] = mk("pri_resume", 0, 1, 3, 32'h33, 0, 0, 0,       0, 1, 3, 32'h33, SRC_WB, 0);
        vt[13] = mk("pri_idle",   0, 0, 0, 0,      0, 0, 0,       0, 1, 0, 0, SRC_NONE, 0);

        for (int i = 0; i < 14; i++) begin
            drv(vt[i].rst, vt[i].wbv, vt[i].wbrd, vt[i].wbd, vt[i].luv, vt[i].lurd, vt[i].lud);
            chk(vt[i].name, outs(),
                80'({vt[i].e_stall, vt[i].e_ready, vt[i].e_addr, vt[i].e_data, vt[i].e_src, vt[i].e_busy}));
            tick();
        end

        // Full FIFO: pipeline keeps x3 busy while LU offers x10, x11, x12.
        begin
            logic [4:0] lrd [7];
            logic       erdy [7];
            lrd  = '{5'd10, 5'd11, 5'd12, 5'd12, 5'd12, 5'd12, 5'd12};
            erdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            for (int c = 0; c < 7; c++) begin
                drv(0, 1, 3, 32'h33, 1, lrd[c], 32'h100 + 32'(lrd[c]));
                chk($sformatf("full_ready_c%0d", c), 80'(o_lu_ready), 80'(erdy[c]));
                if (c == 5)
                    chk("full_force_x10", 80'({o_wb_stall, o_rf_dest_addr, o_rf_data, 2'(o_wr_src)}),
                        80'({1'b1, 5'd10, 32'h10A, 2'(SRC_LU)}));
                tick();
            end
            drv(0, 0, 0, 0, 0, 0, 0);
            chk("full_drain_x11", 80'({o_rf_dest_addr, o_rf_data, 2'(o_wr_src)}), 80'({5'd11, 32'h10B, 2'(SRC_LU)}));
            tick();
            drv(0, 0, 0, 0, 0, 0, 0);
            chk("full_drain_x12", 80'({o_rf_dest_addr, o_rf_data, 2'(o_wr_src)}), 80'({5'd12, 32'h10C, 2'(SRC_LU)}));
            tick();
            drv(0, 0, 0, 0, 0, 0, 0);
            chk("full_empty", 80'({o_rf_dest_addr, 2'(o_wr_src), o_busy_mask}), 80'({5'd0, 2'(SRC_NONE), 32'd0}));
            tick();
        end

        // WAW kill: queued x9=1 overtaken by pipeline x9=2.
        drv(0, 0, 0, 0, 1, 9, 32'd1);
        tick();
        drv(0, 1, 9, 32'd2, 0, 0, 0);
        chk("waw_wb_grant", 80'({o_rf_dest_addr, o_rf_data, 2'(o_wr_src), o_busy_mask}),
            80'({5'd9, 32'd2, 2'(SRC_WB), 32'h200}));
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("waw_dead_pop", 80'({o_rf_dest_addr, 2'(o_wr_src), o_busy_mask}), 80'({5'd0, 2'(SRC_NONE), 32'd0}));
        tick();
        chk("waw_rf_x9", 80'(rf[9]), 80'd2);

        // Same-cycle enqueue to the register the pipeline is writing is stored dead.
        drv(0, 1, 14, 32'd5, 1, 14, 32'd6);
        chk("waw_same_grant", 80'({o_lu_ready, 2'(o_wr_src)}), 80'({1'b1, 2'(SRC_WB)}));
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("waw_same_dead", 80'({o_rf_dest_addr, 2'(o_wr_src), o_busy_mask}), 80'({5'd0, 2'(SRC_NONE), 32'd0}));
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("waw_rf_x14", 80'(rf[14]), 80'd5);
        chk("waw_no_stale", 80'(bad_write), 80'd0);
        tick();

        // x0 requests from both sides.
        drv(0, 1, 0, 32'hFF, 1, 0, 32'hEE);
        chk("x0_no_grant", 80'({o_wb_stall, o_lu_ready, o_rf_dest_addr, o_rf_data, 2'(o_wr_src)}),
            80'({1'b0, 1'b1, 5'd0, 32'd0, 2'(SRC_NONE)}));
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("x0_no_enq", 80'({2'(o_wr_src), o_busy_mask}), 80'({2'(SRC_NONE), 32'd0}));
        tick();

        // Reset with a queued LU result discards it.
        drv(0, 1, 3, 32'h33, 1, 20, 32'h20);
        tick();
        drv(1, 1, 3, 32'h33, 1, 21, 32'h21);
        chk("midrst_outputs", outs(), 80'd0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("midrst_cleared", 80'({o_lu_ready, o_rf_dest_addr, 2'(o_wr_src), o_busy_mask}),
            80'({1'b1, 5'd0, 2'(SRC_NONE), 32'd0}));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
